detection_scheduler: RTL and testbench

DETECTION_SCHEDULER -- requirements
Module: detection_scheduler

---
 rtl/face_det_pkg.sv | 31 +++
 rtl/detection_scheduler_if.sv | 30 +++
 rtl/window_addr_gen.sv | 33 +++
 rtl/detection_scheduler.sv | 178 +++++++++++++++++
 tb/tb_detection_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/face_det_pkg.sv
// Shared face-detection constants: image geometry, address width,
// scheduler state encodings and an address truncation helper.
package face_det_pkg;

  localparam int II_WIDTH  = 160;
  localparam int II_HEIGHT = 120;
  localparam int ADDR_W    = 15;

  // One-hot bit positions of the scheduler state register
  localparam int ST_IDLE   = 0;
  localparam int ST_SETUP  = 1;
  localparam int ST_FIRE   = 2;
  localparam int ST_WAIT   = 3;
  localparam int ST_RECORD = 4;
  localparam int ST_DONE   = 5;

  localparam logic [5:0] S_IDLE   = 6'b000001;
  localparam logic [5:0] S_SETUP  = 6'b000010;
  localparam logic [5:0] S_FIRE   = 6'b000100;
  localparam logic [5:0] S_WAIT   = 6'b001000;
  localparam logic [5:0] S_RECORD = 6'b010000;
  localparam logic [5:0] S_DONE   = 6'b100000;

  // Address math runs at 16 bits; the geometry keeps results < 2^15
  function automatic logic [ADDR_W-1:0] to_addr(
    input logic [15:0] v
  );
    return v[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/detection_scheduler_if.sv
// Scheduler <-> classifier link: start pulse, done/result, six corner
// addresses. master = scheduler side, slave = classifier side.
interface detection_scheduler_if;
  import face_det_pkg::*;

  logic              detect_en;
  logic              detect_done;
  logic              detected_flag;
  logic [ADDR_W-1:0] address_0;
  logic [ADDR_W-1:0] address_1;
  logic [ADDR_W-1:0] address_2;
  logic [ADDR_W-1:0] address_3;
  logic [ADDR_W-1:0] address_4;
  logic [ADDR_W-1:0] address_5;

  modport master (
    output detect_en,
    output address_0, address_1, address_2,
    output address_3, address_4, address_5,
    input  detect_done, detected_flag
  );

  modport slave (
    input  detect_en,
    input  address_0, address_1, address_2,
    input  address_3, address_4, address_5,
    output detect_done, detected_flag
  );

endinterface

// File: rtl/window_addr_gen.sv
// Corner addresses of a vertical two-rectangle feature at (x,y).
// Ports: x, y window origin in; a0..a5 linear y*II_WIDTH+x out.
module window_addr_gen #(
  parameter int II_WIDTH = face_det_pkg::II_WIDTH,
  parameter int WIN_W    = 8,
  parameter int WIN_H    = 8
) (
  input  logic [7:0]                    x,
  input  logic [6:0]                    y,
  output logic [face_det_pkg::ADDR_W-1:0] a0,
  output logic [face_det_pkg::ADDR_W-1:0] a1,
  output logic [face_det_pkg::ADDR_W-1:0] a2,
  output logic [face_det_pkg::ADDR_W-1:0] a3,
  output logic [face_det_pkg::ADDR_W-1:0] a4,
  output logic [face_det_pkg::ADDR_W-1:0] a5
);
  import face_det_pkg::to_addr;

  localparam logic [15:0] DX = 16'(WIN_W);
  localparam logic [15:0] DY = 16'(WIN_H * II_WIDTH);

  logic [15:0] base;

  assign base = 16'(y) * 16'(II_WIDTH) + 16'(x);

  assign a3 = to_addr(base);
  assign a2 = to_addr(base + DX);
  assign a1 = to_addr(base + DY);
  assign a0 = to_addr(base + DY + DX);
  assign a5 = to_addr(base + DY + DY);
  assign a4 = to_addr(base + DY + DY + DX);

endmodule

// File: rtl/detection_scheduler.sv
// Raster-scans feature windows over an integral image, fires the
// classifier per window and tallies hits.
// Ports: clk, rst (sync, active-high), frame_start, scan_abort,
// bus (classifier link, master), scan_busy, scan_done, hit_count,
// hit_valid, hit_x, hit_y, timeout_err.
// Build option: define SCHED_TIMEOUT_EN to bound the classifier wait.
module detection_scheduler #(
  parameter int II_WIDTH  = face_det_pkg::II_WIDTH,
  parameter int II_HEIGHT = face_det_pkg::II_HEIGHT,
  parameter int WIN_W     = 8,
  parameter int WIN_H     = 8,
  parameter int STEP      = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   scan_abort,
  detection_scheduler_if.master  bus,
  output logic                   scan_busy,
  output logic                   scan_done,
  output logic [14:0]            hit_count,
  output logic                   hit_valid,
  output logic [7:0]             hit_x,
  output logic [6:0]             hit_y,
  output logic                   timeout_err
);
  import face_det_pkg::*;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  logic [5:0]        state;
  logic [7:0]        x;
  logic [6:0]        y;
  logic              flag_q;
  logic              x_fits;
  logic              y_fits;
  logic [ADDR_W-1:0] g0, g1, g2, g3, g4, g5;

  window_addr_gen #(
    .II_WIDTH (II_WIDTH),
    .WIN_W    (WIN_W),
    .WIN_H    (WIN_H)
  ) u_gen (
    .x  (x),
    .y  (y),
    .a0 (g0),
    .a1 (g1),
    .a2 (g2),
    .a3 (g3),
    .a4 (g4),
    .a5 (g5)
  );

  // Does the next step still leave the window inside the image
  assign x_fits = 16'(x) + 16'(STEP + WIN_W)
                  <= 16'(II_WIDTH - 1);
  assign y_fits = 16'(y) + 16'(STEP + 2 * WIN_H)
                  <= 16'(II_HEIGHT - 1);

  assign bus.detect_en = state[ST_FIRE];
  assign scan_busy     = !state[ST_IDLE];
  assign scan_done     = state[ST_DONE];

`ifdef SCHED_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;
  logic             expired;

  // Last allowed WAIT cycle; a detect_done here still wins
  assign expired     = wait_cnt == CNT_W'(TIMEOUT - 1);
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      x             <= '0;
      y             <= '0;
      flag_q        <= 1'b0;
      hit_count     <= '0;
      hit_valid     <= 1'b0;
      hit_x         <= '0;
      hit_y         <= '0;
      bus.address_0 <= '0;
      bus.address_1 <= '0;
      bus.address_2 <= '0;
      bus.address_3 <= '0;
      bus.address_4 <= '0;
      bus.address_5 <= '0;
`ifdef SCHED_TIMEOUT_EN
      wait_cnt      <= '0;
      timeout_q     <= 1'b0;
`endif
    end else if (scan_abort && !state[ST_IDLE]) begin
      state <= S_IDLE;
    end else begin
      unique case (1'b1)
        state[ST_IDLE]: begin
          if (frame_start) begin
            state     <= S_SETUP;
            x         <= '0;
            y         <= '0;
            hit_count <= '0;
            hit_valid <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        state[ST_SETUP]: begin
          bus.address_0 <= g0;
          bus.address_1 <= g1;
          bus.address_2 <= g2;
          bus.address_3 <= g3;
          bus.address_4 <= g4;
          bus.address_5 <= g5;
          state         <= S_FIRE;
        end
        state[ST_FIRE]: begin
`ifdef SCHED_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= S_WAIT;
        end
        state[ST_WAIT]: begin
          if (bus.detect_done) begin
            flag_q <= bus.detected_flag;
            state  <= S_RECORD;
          end
`ifdef SCHED_TIMEOUT_EN
          else if (expired) begin
            flag_q    <= 1'b0;
            timeout_q <= 1'b1;
            state     <= S_RECORD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        state[ST_RECORD]: begin
          if (flag_q) begin
            if (hit_count != 15'h7FFF)
              hit_count <= hit_count + 15'd1;
            if (!hit_valid) begin
              hit_valid <= 1'b1;
              hit_x     <= x;
              hit_y     <= y;
            end
          end
          if (x_fits) begin
            x     <= x + 8'(STEP);
            state <= S_SETUP;
          end else if (y_fits) begin
            x     <= '0;
            y     <= y + 7'(STEP);
            state <= S_SETUP;
          end else begin
            state <= S_DONE;
          end
        end
        state[ST_DONE]: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_detection_scheduler.sv
// Scoreboard bench for detection_scheduler: randomized hit maps and
// classifier latencies against a window-list reference model.
module tb_detection_scheduler;
  import face_det_pkg::*;

  localparam int W  = 160;
  localparam int H  = 120;
  localparam int WW = 8;
  localparam int WH = 8;
  localparam int ST = 4;
  localparam int NX = (W - 1 - WW) / ST + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        scan_abort = 1'b0;
  logic        scan_busy;
  logic        scan_done;
  logic [14:0] hit_count;
  logic        hit_valid;
  logic [7:0]  hit_x;
  logic [6:0]  hit_y;
  logic        timeout_err;

  detection_scheduler_if bus();

  detection_scheduler #(
    .II_WIDTH  (W),
    .II_HEIGHT (H),
    .WIN_W     (WW),
    .WIN_H     (WH),
    .STEP      (ST),
    .TIMEOUT   (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .scan_abort  (scan_abort),
    .bus         (bus),
    .scan_busy   (scan_busy),
    .scan_done   (scan_done),
    .hit_count   (hit_count),
    .hit_valid   (hit_valid),
    .hit_x       (hit_x),
    .hit_y       (hit_y),
    .timeout_err (timeout_err)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
  } win_t;

  typedef struct {
    int hits;
    bit hv;
    int hx;
    int hy;
    bit terr;
    int nwin;
  } res_t;

  win_t exp_win[$];
  res_t exp_res[$];
  win_t cur_win;
  bit   have_cur = 0;
  bit   pos_map [W][H];

  int n_cmp = 0;
  int n_bad = 0;
  int lat_fix = 1;
  int cls_idx = 0;
  int skip_idx = -1;
  int slow_idx = -1;
  int slow_lat = 0;
  int en_scan = 0;
  int done_cnt = 0;

  task automatic check(string nm, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic all_out_or();
    return |{bus.address_0, bus.address_1, bus.address_2,
             bus.address_3, bus.address_4, bus.address_5,
             bus.detect_en, scan_busy, scan_done, hit_count,
             hit_valid, hit_x, hit_y, timeout_err};
  endfunction

  // Reference: every window whose feature fits inside the image,
  // visited row by row; skipped (timed-out) windows count negative.
  task automatic issue_scan(bit terr);
    res_t r;
    int   idx;
    r = '{0, 1'b0, 0, 0, terr, 0};
    idx = 0;
    for (int yy = 0; yy + 2 * WH <= H - 1; yy += ST)
      for (int xx = 0; xx + WW <= W - 1; xx += ST) begin
        win_t w;
        w.x = xx;
        w.y = yy;
        exp_win.push_back(w);
        r.nwin++;
        if (pos_map[xx][yy] && idx != skip_idx) begin
          r.hits++;
          if (!r.hv) begin
            r.hv = 1'b1;
            r.hx = xx;
            r.hy = yy;
          end
        end
        idx++;
      end
    exp_res.push_back(r);
    cls_idx = 0;
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  task automatic flush();
    exp_win.delete();
    exp_res.delete();
    en_scan = 0;
    have_cur = 1'b0;
  endtask

  task automatic clear_map();
    for (int i = 0; i < W; i++)
      for (int j = 0; j < H; j++)
        pos_map[i][j] = 1'b0;
  endtask

  task automatic wait_done(int maxc);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < maxc && done_cnt == d0; i++)
      @(posedge clk);
    #1;
    check("scan_done_seen", longint'(done_cnt != d0), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_en(int n, int maxc);
    for (int i = 0; i < maxc && en_scan < n; i++) begin
      @(posedge clk);
      #1;
    end
    check("wait_detect_en", longint'(en_scan >= n), 1);
  endtask

  // Classifier model: answers each detect_en after a latency
  initial begin : classifier
    int idx;
    int lat;
    int wx;
    int wy;
    bus.detect_done = 1'b0;
    bus.detected_flag = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.detect_en && !rst) begin
        idx = cls_idx;
        cls_idx++;
        wx = (idx % NX) * ST;
        wy = (idx / NX) * ST;
        if (idx != skip_idx) begin
          if (idx == slow_idx) lat = slow_lat;
          else if (lat_fix > 0) lat = lat_fix;
          else lat = int'($urandom_range(3, 1));
          repeat (lat) @(posedge clk);
          #1;
          bus.detect_done = 1'b1;
          bus.detected_flag = pos_map[wx][wy];
          @(posedge clk);
          #1;
          bus.detect_done = 1'b0;
          bus.detected_flag = 1'b0;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents output
  initial begin : monitor
    res_t r;
    forever begin
      @(negedge clk);
      if (bus.detect_en) begin
        en_scan++;
        if (exp_win.size() == 0) begin
          check("unexpected_detect_en", 1, 0);
        end else begin
          cur_win = exp_win.pop_front();
          have_cur = 1'b1;
          check("a3", bus.address_3, cur_win.y * W + cur_win.x);
          check("a2", bus.address_2,
                cur_win.y * W + cur_win.x + WW);
          check("a1", bus.address_1,
                (cur_win.y + WH) * W + cur_win.x);
          check("a0", bus.address_0,
                (cur_win.y + WH) * W + cur_win.x + WW);
          check("a5", bus.address_5,
                (cur_win.y + 2 * WH) * W + cur_win.x);
          check("a4", bus.address_4,
                (cur_win.y + 2 * WH) * W + cur_win.x + WW);
          if (cur_win.x == 4 && cur_win.y == 0) begin
            check("x4y0_a3", bus.address_3, 4);
            check("x4y0_a2", bus.address_2, 12);
            check("x4y0_a1", bus.address_1, 1284);
            check("x4y0_a0", bus.address_0, 1292);
            check("x4y0_a5", bus.address_5, 2564);
            check("x4y0_a4", bus.address_4, 2572);
          end
          if (cur_win.x == 148 && cur_win.y == 100) begin
            check("last_a3", bus.address_3, 16148);
            check("last_a4", bus.address_4, 18716);
          end
        end
      end
      if (bus.detect_done && scan_busy && have_cur)
        check("addr_hold", bus.address_3,
              cur_win.y * W + cur_win.x);
      if (scan_done) begin
        done_cnt++;
        if (exp_res.size() == 0) begin
          check("unexpected_scan_done", 1, 0);
        end else begin
          r = exp_res.pop_front();
          check("win_count", en_scan, r.nwin);
          check("hit_count", hit_count, r.hits);
          check("hit_valid", hit_valid, r.hv);
          if (r.hv) begin
            check("hit_x", hit_x, r.hx);
            check("hit_y", hit_y, r.hy);
          end
          check("timeout_err", timeout_err, r.terr);
          check("leftover_windows", exp_win.size(), 0);
        end
        en_scan = 0;
        have_cur = 1'b0;
      end
    end
  end

  initial begin : main
    int d0;
    clear_map();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_out_or(), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", scan_busy, 0);

    // all negative, 11-cycle classifier
    lat_fix = 11;
    issue_scan(1'b0);
    wait_done(20000);

    // two positives
    pos_map[20][8] = 1'b1;
    pos_map[148][100] = 1'b1;
    lat_fix = 2;
    issue_scan(1'b0);
    wait_done(10000);

    // random hits, random latency, stray frame_start mid-scan
    clear_map();
    for (int i = 0; i < W; i++)
      for (int j = 0; j < H; j++)
        pos_map[i][j] = ($urandom_range(29, 0) == 0);
    lat_fix = 0;
    issue_scan(1'b0);
    repeat (200) @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    check("busy_after_stray_start", scan_busy, 1);
    wait_done(10000);

    // abort in WAIT of window 5
    clear_map();
    lat_fix = 1;
    skip_idx = 5;
    issue_scan(1'b0);
    wait_en(6, 500);
    d0 = done_cnt;
    scan_abort = 1'b1;
    @(posedge clk);
    #1 scan_abort = 1'b0;
    check("abort_busy", scan_busy, 0);
    check("abort_detect_en", bus.detect_en, 0);
    flush();
    skip_idx = -1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, d0);
    check("abort_idle", scan_busy, 0);

    // restart from (0,0) after abort
    pos_map[0][0] = 1'b1;
    issue_scan(1'b0);
    wait_done(10000);

    // rst mid-scan
    issue_scan(1'b0);
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("midscan_reset_outputs", all_out_or(), 0);
    rst = 1'b0;
    flush();
    repeat (20) @(posedge clk);
    #1;
    check("post_reset_idle", scan_busy, 0);

`ifdef SCHED_TIMEOUT_EN
    // window 0 never answered
    clear_map();
    pos_map[0][0] = 1'b1;
    pos_map[40][4] = 1'b1;
    skip_idx = 0;
    issue_scan(1'b1);
    wait_en(2, 200);
    check("timeout_set", timeout_err, 1);
    check("timeout_continues", scan_busy, 1);
    wait_done(10000);
    skip_idx = -1;

    // answer on the 64th WAIT cycle: no error
    slow_idx = 0;
    slow_lat = 64;
    issue_scan(1'b0);
    wait_done(10000);
    slow_idx = -1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
